logic_op_using_mux_pipe: RTL and testbench

//   Pipelined, WIDTH-bit bitwise logic unit (AND/OR/XOR/XNOR) whose gates are

---
 rtl/logic_op_using_mux_pipe.sv | 122 ++++++++++++
 tb/tb_logic_op_using_mux_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_using_mux_pipe.sv
// rtl/logic_op_using_mux_pipe.sv - mux-built AND/OR/XOR/XNOR unit behind a valid/ready register pipeline
// Optional registered parity output on down_par: define PARITY_OUT_EN.

module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

`ifdef PARITY_OUT_EN
module mux_xor (
  input  logic a,
  input  logic b,
  output logic y
);
  logic and_y, or_y, nand_y;
  mux u_and  (.d0(1'b0), .d1(b),    .sel(a),     .y(and_y));
  mux u_or   (.d0(b),    .d1(1'b1), .sel(a),     .y(or_y));
  mux u_nand (.d0(1'b1), .d1(1'b0), .sel(and_y), .y(nand_y));
  mux u_xor  (.d0(1'b0), .d1(nand_y), .sel(or_y), .y(y));
endmodule
`endif

module logic_op_using_mux_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_a,
  input  logic [WIDTH-1:0] up_b,
  input  logic [1:0]       up_op,
  output logic             down_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] down_res,
  output logic             down_par
);

  logic [WIDTH-1:0] res_d;

  // Every gate and the op select are 2:1 mux instances; no logic operators on data.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic and_y, or_y, nand_y, xor_y, xnor_y, sel_lo, sel_hi;
    mux u_and  (.d0(1'b0),   .d1(up_b[i]), .sel(up_a[i]),   .y(and_y));
    mux u_or   (.d0(up_b[i]), .d1(1'b1),   .sel(up_a[i]),   .y(or_y));
    mux u_nand (.d0(1'b1),   .d1(1'b0),    .sel(and_y),     .y(nand_y));
    mux u_xor  (.d0(1'b0),   .d1(nand_y),  .sel(or_y),      .y(xor_y));
    mux u_xnor (.d0(1'b1),   .d1(1'b0),    .sel(xor_y),     .y(xnor_y));
    mux u_lo   (.d0(and_y),  .d1(or_y),    .sel(up_op[0]),  .y(sel_lo));
    mux u_hi   (.d0(xor_y),  .d1(xnor_y),  .sel(up_op[0]),  .y(sel_hi));
    mux u_top  (.d0(sel_lo), .d1(sel_hi),  .sel(up_op[1]),  .y(res_d[i]));
  end

`ifdef PARITY_OUT_EN
  logic [WIDTH-1:0] par_chain;
  logic             par_d;
  logic             par_q [STAGES];

  assign par_chain[0] = res_d[0];
  for (genvar i = 1; i < WIDTH; i++) begin : g_par
    mux_xor u_px (.a(par_chain[i-1]), .b(res_d[i]), .y(par_chain[i]));
  end
  assign par_d = par_chain[WIDTH-1];
`endif

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  res_q [STAGES];

  // A stage can load unless it and every stage after it are full while the consumer stalls.
  for (genvar k = 0; k < STAGES; k++) begin : g_load
    assign load[k] = !(&v[STAGES-1:k]) || down_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
`ifdef PARITY_OUT_EN
        par_q[k] <= 1'b0;
`endif
      end
    end else begin
      if (load[0]) begin
        v[0] <= up_valid;
        if (up_valid) begin
          res_q[0] <= res_d;
`ifdef PARITY_OUT_EN
          par_q[0] <= par_d;
`endif
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            res_q[k] <= res_q[k-1];
`ifdef PARITY_OUT_EN
            par_q[k] <= par_q[k-1];
`endif
          end
        end
      end
    end
  end

  assign up_ready   = load[0];
  assign down_valid = v[STAGES-1];
  assign down_res   = res_q[STAGES-1];
`ifdef PARITY_OUT_EN
  assign down_par   = par_q[STAGES-1];
`else
  assign down_par   = 1'b0;
`endif

endmodule

// File: tb/tb_logic_op_using_mux_pipe.sv
// tb/tb_logic_op_using_mux_pipe.sv - bench for logic_op_using_mux_pipe at STAGES 1, 2 and 4
module tb_logic_op_using_mux_pipe;

  int checks = 0;
  int errors = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up_valid;
  logic [7:0] up_a, up_b;
  logic [1:0] up_op;
  logic       down_ready;
  logic [2:0] ur, dv, dp;
  logic [7:0] dr [3];

  logic [8:0] mq [3][$];

  always #5 clk = ~clk;

  logic_op_using_mux_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur[0]),
    .up_a(up_a), .up_b(up_b), .up_op(up_op), .down_valid(dv[0]),
    .down_ready(down_ready), .down_res(dr[0]), .down_par(dp[0]));
  logic_op_using_mux_pipe #(.WIDTH(8), .STAGES(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur[1]),
    .up_a(up_a), .up_b(up_b), .up_op(up_op), .down_valid(dv[1]),
    .down_ready(down_ready), .down_res(dr[1]), .down_par(dp[1]));
  logic_op_using_mux_pipe #(.WIDTH(8), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(ur[2]),
    .up_a(up_a), .up_b(up_b), .up_op(up_op), .down_valid(dv[2]),
    .down_ready(down_ready), .down_res(dr[2]), .down_par(dp[2]));

  function automatic int depth(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  // Reference result {parity, result} straight from the operation table.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [7:0] r;
    logic       p;
    case (op)
      2'd0:    r = a & b;
      2'd1:    r = a | b;
      2'd2:    r = a ^ b;
      default: r = ~(a ^ b);
    endcase
`ifdef PARITY_OUT_EN
    p = ^r;
`else
    p = 1'b0;
`endif
    return {p, r};
  endfunction

  task automatic flush();
    up_valid = 1'b0;
    down_ready = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; up_valid = 1'b0; down_ready = 1'b0;
    up_a = '0; up_b = '0; up_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dv[i] !== 1'b0 || dr[i] !== 8'h00 || dp[i] !== 1'b0 || ur[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d: valid=%b res=%h par=%b ready=%b required 0/00/0/1", i, dv[i], dr[i], dp[i], ur[i]);
      end
    end
  endtask

  task automatic test_ops();
    logic [7:0] exp_ops [4];
    exp_ops = '{8'h24, 8'hBD, 8'h99, 8'h66};
    flush();
    for (int op = 0; op < 4; op++) begin
      @(negedge clk);
      up_valid = 1'b1; up_a = 8'hA5; up_b = 8'h3C; up_op = op[1:0];
      #1;
      checks++;
      if (ur[1] !== 1'b1) begin errors++; $display("FAIL ops_ready op%0d: got %b required 1", op, ur[1]); end
      @(negedge clk);
      up_valid = 1'b0;
      #1;
      checks++;
      if (dv[1] !== 1'b0) begin errors++; $display("FAIL ops_early op%0d: valid %b required 0", op, dv[1]); end
      @(negedge clk);
      #1;
      checks++;
      if (dv[1] !== 1'b1 || dr[1] !== exp_ops[op]) begin
        errors++;
        $display("FAIL ops_result op%0d: valid=%b res=%h required 1/%h", op, dv[1], dr[1], exp_ops[op]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] q [$];
    int sent = 0, rx = 0, first = -1, last = -1;
    logic [8:0] e;
    flush();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (dv[1]) begin
        e = (q.size() > 0) ? q.pop_front() : 9'h1xx;
        checks++;
        if (dr[1] !== e[7:0]) begin errors++; $display("FAIL b2b_data #%0d: got %h required %h", rx, dr[1], e[7:0]); end
        if (first < 0) first = c;
        last = c;
        rx++;
      end
      if (sent < 16) begin
        up_valid = 1'b1; up_a = 8'($urandom); up_b = 8'($urandom); up_op = 2'($urandom);
      end else up_valid = 1'b0;
      #1;
      if (up_valid) begin
        checks++;
        if (ur[1] !== 1'b1) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b required 1", c, ur[1]); end
        else begin q.push_back(model(up_a, up_b, up_op)); sent++; end
      end
    end
    checks++;
    if (rx != 16 || last - first != 15) begin
      errors++;
      $display("FAIL b2b_stream: results=%0d span=%0d required 16/15", rx, last - first);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] q [$];
    logic [7:0] hold = '0;
    logic       have_hold = 1'b0;
    int         acc = 0;
    logic [8:0] e;
    flush();
    down_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (dv[1]) begin
        checks++;
        if (have_hold && dr[1] !== hold) begin errors++; $display("FAIL bp_stable cycle %0d: got %h required %h", c, dr[1], hold); end
        if (!have_hold) begin hold = dr[1]; have_hold = 1'b1; end
      end
      if (!up_valid || acc == 0 || q.size() < acc) begin end
      up_valid = 1'b1; up_a = 8'($urandom); up_b = 8'($urandom); up_op = 2'($urandom);
      #1;
      if (ur[1]) begin q.push_back(model(up_a, up_b, up_op)); acc++; end
    end
    checks++;
    if (acc != 2 || ur[1] !== 1'b0 || dv[1] !== 1'b1) begin
      errors++;
      $display("FAIL bp_fill: accepts=%0d ready=%b valid=%b required 2/0/1", acc, ur[1], dv[1]);
    end
    @(negedge clk);
    up_valid = 1'b0; down_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (dv[1]) begin
        e = (q.size() > 0) ? q.pop_front() : 9'h1xx;
        checks++;
        if (dr[1] !== e[7:0]) begin errors++; $display("FAIL bp_drain: got %h required %h", dr[1], e[7:0]); end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL bp_drain_count: left %0d required 0", q.size()); end
  endtask

  task automatic test_reset_mid();
    flush();
    down_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      up_valid = 1'b1; up_a = 8'($urandom); up_b = 8'($urandom); up_op = 2'($urandom);
    end
    @(negedge clk);
    up_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (dv !== 3'b000) begin errors++; $display("FAIL rst_mid_valid: got %b required 000", dv); end
    down_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (dv !== 3'b000) begin errors++; $display("FAIL rst_mid_stale cycle %0d: got %b required 000", c, dv); end
    end
  endtask

  task automatic test_parity();
    logic [7:0] pa [2], pb [2], pr [2];
    logic [1:0] po [2];
    logic       pp [2];
    pa = '{8'hFF, 8'hFF}; pb = '{8'h01, 8'h03}; po = '{2'd2, 2'd0};
    pr = '{8'hFE, 8'h03};
`ifdef PARITY_OUT_EN
    pp = '{1'b1, 1'b0};
`else
    pp = '{1'b0, 1'b0};
`endif
    flush();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      up_valid = 1'b1; up_a = pa[t]; up_b = pb[t]; up_op = po[t];
      @(negedge clk);
      up_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (dv[1] !== 1'b1 || dr[1] !== pr[t] || dp[1] !== pp[t]) begin
        errors++;
        $display("FAIL parity #%0d: valid=%b res=%h par=%b required 1/%h/%b", t, dv[1], dr[1], dp[1], pr[t], pp[t]);
      end
    end
  endtask

  task automatic test_stall_sweep();
    logic       hold_v [3];
    logic [8:0] hold_d [3];
    logic [8:0] e;
    flush();
    for (int i = 0; i < 3; i++) begin hold_v[i] = 1'b0; hold_d[i] = '0; end
    for (int c = 0; c < 412; c++) begin
      @(negedge clk);
      if (c < 400) begin
        up_valid = ($urandom_range(3) != 0);
        down_ready = ($urandom_range(2) != 0);
      end else begin
        up_valid = 1'b0;
        down_ready = 1'b1;
      end
      up_a = 8'($urandom); up_b = 8'($urandom); up_op = 2'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (hold_v[i]) begin
          checks++;
          if (dv[i] !== 1'b1 || {dp[i], dr[i]} !== hold_d[i]) begin
            errors++;
            $display("FAIL sweep_hold dut%0d: valid=%b data=%h required 1/%h", i, dv[i], {dp[i], dr[i]}, hold_d[i]);
          end
        end
        checks++;
        if (ur[i] !== ((mq[i].size() < depth(i)) || down_ready)) begin
          errors++;
          $display("FAIL sweep_ready dut%0d: got %b occupancy %0d", i, ur[i], mq[i].size());
        end
        if (dv[i] && down_ready) begin
          e = (mq[i].size() > 0) ? mq[i].pop_front() : 9'h1xx;
          checks++;
          if ({dp[i], dr[i]} !== e) begin
            errors++;
            $display("FAIL sweep_data dut%0d: got %h required %h", i, {dp[i], dr[i]}, e);
          end
        end
        hold_v[i] = dv[i] && !down_ready;
        hold_d[i] = {dp[i], dr[i]};
        if (up_valid && ur[i]) mq[i].push_back(model(up_a, up_b, up_op));
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mq[i].size() != 0 || dv[i] !== 1'b0) begin
        errors++;
        $display("FAIL sweep_drain dut%0d: left %0d valid %b required 0/0", i, mq[i].size(), dv[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_parity();
    test_stall_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
